wm8731_dac_i2s: RTL and testbench

Audio serial transmitter that streams stereo PCM samples from the synth core to the WM8731 DAC in I2S master mode. It generates BCLK, DACLRC and DACDAT from an internal clock divider and buffers one stereo sample via a valid/ready handshake. It sits downstream of the codec configuration sequencer and is held idle until that sequencer reports the codec configured.

---
 rtl/wm8731_pkg.sv | 44 ++++
 rtl/wm8731_dac_i2s_bclk_gen.sv | 37 +++
 rtl/wm8731_dac_i2s.sv | 102 ++++++++++
 tb/tb_wm8731_dac_i2s.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_pkg.sv
// Shared WM8731 codec definitions: I2C address, register map and digital
// audio interface field encodings used by the config sequencer and the I2S path.
package wm8731_pkg;

    localparam logic [6:0] WM8731_I2C_ADDR = 7'h1A;

    localparam logic [6:0] REG_DIG_IF_FMT  = 7'h07;
    localparam logic [6:0] REG_SAMPLING    = 7'h08;
    localparam logic [6:0] REG_RESET       = 7'h0F;

    typedef enum logic [1:0] {
        FMT_RIGHT_J = 2'b00,
        FMT_LEFT_J  = 2'b01,
        FMT_I2S     = 2'b10,
        FMT_DSP     = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        IWL_16 = 2'b00,
        IWL_20 = 2'b01,
        IWL_24 = 2'b10,
        IWL_32 = 2'b11
    } iwl_e;

    typedef enum logic {
        CHAN_LEFT  = 1'b0,
        CHAN_RIGHT = 1'b1
    } chan_e;

    function automatic iwl_e iwl_for_width(input int width);
        case (width)
            20:      return IWL_20;
            24:      return IWL_24;
            32:      return IWL_32;
            default: return IWL_16;
        endcase
    endfunction

    // Codec runs as slave (MS bit 6 clear) because this block drives BCLK/DACLRC.
    function automatic logic [8:0] dig_if_fmt_word(input fmt_e fmt, input iwl_e iwl);
        return {5'b00000, iwl, fmt};
    endfunction

endpackage

// File: rtl/wm8731_dac_i2s_bclk_gen.sv
// BCLK generator: divides clk by 2*CLK_DIV and flags the clk cycle on which
// bclk is about to fall, which is when every serial output is allowed to change.
module bclk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic fall_evt
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             div_wrap;

    assign div_wrap = (div == DIV_LAST);
    assign fall_evt = enable && bclk && div_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (!enable) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (div_wrap) begin
            div  <= '0;
            bclk <= ~bclk;
        end else begin
            div  <= div + 1'b1;
        end
    end

endmodule

// File: rtl/wm8731_dac_i2s.sv
// I2S master transmitter for the WM8731 DAC: one-deep stereo hold buffer,
// slot counter and MSB-first shift register with the I2S one-BCLK data delay.
module wm8731_dac_i2s
    import wm8731_pkg::*;
#(
    parameter int CLK_DIV  = 8,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                bclk,
    output logic                daclrc,
    output logic                dacdat,
    output logic                underrun
);

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int K_W     = $clog2(FRAME_W);
    localparam logic [K_W-1:0] K_LAST  = K_W'(FRAME_W - 1);
    localparam logic [K_W-1:0] K_RIGHT = K_W'(SAMPLE_W);

    logic                       fall_evt;
    logic [K_W-1:0]             k;
    logic [K_W-1:0]             k_next;
    chan_e                      chan_next;
    logic                       hold_full;
    logic signed [SAMPLE_W-1:0] hold_left;
    logic signed [SAMPLE_W-1:0] hold_right;
    logic [FRAME_W-1:0]         shift_reg;
    logic                       xfer;
    logic                       frame_load;

    bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

    assign s_ready    = enable && !reset && !hold_full;
    assign xfer       = s_valid && s_ready;
    assign k_next     = (k == K_LAST) ? '0 : k + 1'b1;
    assign chan_next  = (k_next >= K_RIGHT) ? CHAN_RIGHT : CHAN_LEFT;
    assign frame_load = fall_evt && (k_next == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k         <= K_LAST;
            hold_full <= 1'b0;
            shift_reg <= '0;
            daclrc    <= 1'b0;
            dacdat    <= 1'b0;
            underrun  <= 1'b0;
        end else if (!enable) begin
            k         <= K_LAST;
            hold_full <= 1'b0;
            shift_reg <= '0;
            daclrc    <= 1'b0;
            dacdat    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (xfer) begin
                hold_full <= 1'b1;
            end
            if (fall_evt) begin
                k      <= k_next;
                daclrc <= chan_next;
                // Old MSB goes out first: this is the one-BCLK I2S delay.
                dacdat <= shift_reg[FRAME_W-1];
                if (frame_load) begin
                    if (hold_full) begin
                        shift_reg <= {hold_left, hold_right};
                        hold_full <= 1'b0;
                    end else begin
                        shift_reg <= '0;
                        underrun  <= 1'b1;
                    end
                end else begin
                    shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

    // Sample payload only; its validity is carried by hold_full.
    always_ff @(posedge clk) begin
        if (xfer) begin
            hold_left  <= s_left;
            hold_right <= s_right;
        end
    end

endmodule

// File: tb/tb_wm8731_dac_i2s.sv
// Randomized bench for wm8731_dac_i2s against a cycle-count/frame-list model.
module tb_wm8731_dac_i2s;

    localparam int CD = 4;
    localparam int SW = 16;
    localparam int FW = 2 * SW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          s_valid;
    logic          s_ready;
    logic [SW-1:0] s_left;
    logic [SW-1:0] s_right;
    logic          bclk;
    logic          daclrc;
    logic          dacdat;
    logic          underrun;

    wm8731_dac_i2s #(
        .CLK_DIV  (CD),
        .SAMPLE_W (SW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .bclk     (bclk),
        .daclrc   (daclrc),
        .dacdat   (dacdat),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: n = clk edges since enable went active; words = frame contents in order.
    int            n;
    bit            m_full;
    logic [FW-1:0] m_hold;
    logic [FW-1:0] words[$];
    bit            m_und;
    bit            m_xfer;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int e;
        if (reset || !enable) begin
            n      = 0;
            m_full = 0;
            m_und  = 0;
            m_xfer = 0;
            words.delete();
        end else begin
            m_xfer = s_valid && !m_full;
            m_und  = 0;
            n++;
            e = n / (2 * CD);
            if ((n % (2 * CD) == 0) && (e % FW == 1)) begin
                if (m_full) begin
                    words.push_back(m_hold);
                    m_full = 0;
                end else begin
                    words.push_back('0);
                    m_und = 1;
                end
            end
            if (m_xfer) begin
                m_full = 1;
                m_hold = {s_left, s_right};
            end
        end
    endtask

    task automatic check_outputs();
        int            e;
        int            p;
        logic [FW-1:0] w;
        logic          exp_lrc;
        logic          exp_dat;
        e       = n / (2 * CD);
        exp_lrc = (e >= 1) ? (((FW - 1 + e) % FW) >= SW) : 1'b0;
        exp_dat = 1'b0;
        if (e >= 2) begin
            p = e - 2;
            w = (p / FW < words.size()) ? words[p / FW] : '0;
            exp_dat = w[FW - 1 - (p % FW)];
        end
        check("bclk",     32'(bclk),     32'((n / CD) % 2));
        check("daclrc",   32'(daclrc),   32'(exp_lrc));
        check("dacdat",   32'(dacdat),   32'(exp_dat));
        check("underrun", 32'(underrun), 32'(m_und));
        check("s_ready",  32'(s_ready),  32'(enable && !reset && !m_full));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic offer(input logic [SW-1:0] l, input logic [SW-1:0] r);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        m_xfer  = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (m_xfer) break;
        end
        check("offer_accepted", 32'(m_xfer), 32'd1);
        s_valid = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_left  = '0;
        s_right = '0;
        n       = 0;
        m_full  = 0;
        m_und   = 0;
        m_xfer  = 0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Single known sample, then frames run dry.
        enable = 1'b1;
        offer(16'hA5C3, 16'h0F01);
        repeat (300) tick();

        // Fresh enable with no samples at all.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (400) tick();

        // Back-to-back: s_valid held high with changing data.
        s_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            tick();
        end

        // Restart, then drop enable in the middle of the left word.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (60) tick();
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        repeat (300) tick();

        // Random valid pattern and data.
        for (int i = 0; i < 1500; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            tick();
        end

        // Asynchronous reset mid-frame clears outputs before the next edge.
        s_valid = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        check("rst_bclk",     32'(bclk),     32'd0);
        check("rst_daclrc",   32'(daclrc),   32'd0);
        check("rst_dacdat",   32'(dacdat),   32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_s_ready",  32'(s_ready),  32'd0);
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
